// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB slave GPIO block with synchronized inputs and rise/fall edge interrupts
module apb_gpio_irq #(
  parameter int GPIO_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int PROT_CHECK  = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [2:0]        PPROT,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d, phase;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] off;
  logic err, ready, commit;
  logic [GPIO_W-1:0] wd, sel, w1c, rise, fall;
  logic [GPIO_W-1:0] dout_q, dout_d, dir_q, dir_d, ren_q, ren_d, fen_q, fen_d, stat_q, stat_d;
  logic [GPIO_W-1:0] sync_q, din_q, prev_q;
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:5], PPROT[2:1], PWDATA};
  // bus phase (setup is seen combinationally in IDLE), wait counter and next state
  always_comb begin
    phase   = (state_q == IDLE && PSEL && !PENABLE) ? SETUP : state_q;
    ready   = phase == ACCESS && cnt_q == 4'(WAIT_STATES);
    state_d = phase == SETUP ? ACCESS : (phase == ACCESS && (ready || !PSEL)) ? IDLE : phase;
    cnt_d   = (phase == ACCESS && !ready) ? cnt_q + 4'd1 : 4'd0;
  end
  // address decode, error classification and register next-state
  always_comb begin
    off    = PADDR[4:0];
    err    = off > 5'h14 || off[1:0] != 2'b00 || (PWRITE && off == 5'h08) || (PROT_CHECK != 0 && PWRITE && !PPROT[0]);
    commit = PSEL && PENABLE && PWRITE && ready && !err;
    wd     = PWDATA[GPIO_W-1:0];
    dout_d = (commit && off == 5'h00) ? wd : dout_q;
    dir_d  = (commit && off == 5'h04) ? wd : dir_q;
    ren_d  = (commit && off == 5'h0C) ? wd : ren_q;
    fen_d  = (commit && off == 5'h10) ? wd : fen_q;
    w1c    = (commit && off == 5'h14) ? wd : '0;
    rise   = din_q & ~prev_q & ren_q;
    fall   = ~din_q & prev_q & fen_q;
    stat_d = (stat_q & ~w1c) | rise | fall;
  end
  // read mux and transfer response
  always_comb begin
    sel = off == 5'h00 ? dout_q :
          off == 5'h04 ? dir_q  :
          off == 5'h08 ? din_q  :
          off == 5'h0C ? ren_q  :
          off == 5'h10 ? fen_q  :
          off == 5'h14 ? stat_q : '0;
    PREADY  = ready;
    PSLVERR = ready && err;
    PRDATA  = (ready && !PWRITE && !err) ? 32'(sel) : 32'd0;
  end
  // state, registers and input synchronizer chain
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      dir_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      stat_q  <= '0;
      sync_q  <= '0;
      din_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      stat_q  <= stat_d;
      sync_q  <= gpio_in;
      din_q   <= sync_q;
      prev_q  <= din_q;
    end
  end
  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = |stat_q;
endmodule

// File: doc/apb_gpio_irq.md
APB_GPIO_IRQ -- requirements
Module: apb_gpio_irq

Interface
REQ-001 SHALL have parameter GPIO_W, default 8, number of GPIO pins (1..32).
REQ-002 SHALL have parameter WAIT_STATES, default 0, APB access-phase wait cycles (0..15).
REQ-003 SHALL have parameter PROT_CHECK, default 1; 1 = non-privileged writes are rejected.
REQ-004 SHALL have port PCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port PRESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port PSEL  input  1  APB slave select.
REQ-007 SHALL have port PENABLE  input  1  APB access phase.
REQ-008 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-009 SHALL have port PADDR  input  32  byte address; only PADDR[4:0] decoded.
REQ-010 SHALL have port PWDATA  input  32  write data.
REQ-011 SHALL have port PPROT  input  3  protection; PPROT[0]=1 privileged.
REQ-012 SHALL have port PRDATA  output  32  read data.
REQ-013 SHALL have port PREADY  output  1  transfer complete.
REQ-014 SHALL have port PSLVERR  output  1  transfer error, valid with PREADY.
REQ-015 SHALL have port gpio_in  input  GPIO_W  asynchronous pin inputs.
REQ-016 SHALL have port gpio_out  output  GPIO_W  pin output values.
REQ-017 SHALL have port gpio_oe  output  GPIO_W  pin output enables, 1 = drive.
REQ-018 SHALL have port irq  output  1  interrupt request, level, active-high.

Function
REQ-019 SHALL implement register map: 0x00 DOUT RW; 0x04 DIR RW; 0x08 DIN RO; 0x0C RISE_EN RW; 0x10 FALL_EN RW; 0x14 STATUS W1C.
REQ-020 SHALL implement APB FSM: IDLE -> SETUP on PSEL&!PENABLE; SETUP -> ACCESS; ACCESS holds while wait counter < WAIT_STATES; ACCESS -> IDLE (or SETUP if PSEL&!PENABLE) the cycle PREADY=1.
REQ-021 SHALL assert PREADY exactly WAIT_STATES cycles after entering ACCESS (same cycle when 0); PREADY=0 in IDLE/SETUP.
REQ-022 SHALL commit writes only on the cycle PSEL&PENABLE&PWRITE&PREADY, and only when PSLVERR=0.
REQ-023 SHALL assert PSLVERR with PREADY when: offset > 0x14; PADDR[1:0]!=0; write to DIN; or PROT_CHECK=1 and write with PPROT[0]=0.
REQ-024 SHALL drive PRDATA with the selected register, zero-extended from GPIO_W, while PREADY=1 on reads; PRDATA=0 otherwise and on error.
REQ-025 SHALL ignore PWDATA bits [31:GPIO_W]; unused register bits read 0.
REQ-026 SHALL drive gpio_out=DOUT and gpio_oe=DIR directly from registers.
REQ-027 SHALL pass gpio_in through a 2-flop synchronizer; DIN = synchronizer output, visible 2 edges after pin change.
REQ-028 SHALL hold a third flop (previous DIN); rise = DIN&~prev&RISE_EN, fall = ~DIN&prev&FALL_EN.
REQ-029 SHALL set STATUS[i] on the edge following a detected rise/fall on pin i (pin change to STATUS set = 3 edges).
REQ-030 SHALL clear STATUS[i] on a committed write of 1 to bit i of STATUS; writing 0 has no effect.
REQ-031 SHALL give set priority over W1C clear when both occur in the same cycle.
REQ-032 SHALL drive irq = OR of STATUS bits (combinational from STATUS register).
REQ-033 SHALL detect edges independent of DIR (output pins looped back via gpio_in also interrupt).
REQ-034 SHALL abort any transfer in progress when PRESET asserts; FSM returns to IDLE, no register commit.

Reset
REQ-035 SHALL, while PRESET=1 at a PCLK edge, clear DOUT, DIR, RISE_EN, FALL_EN, STATUS, synchronizer and prev flops to 0.
REQ-036 SHALL, after reset, drive PREADY=0, PSLVERR=0, PRDATA=0, gpio_out=0, gpio_oe=0, irq=0.

Verification
REQ-037 Write 0x5A to 0x00, 0xFF to 0x04, read 0x00 (WAIT_STATES=0) -> gpio_out=0x5A, gpio_oe=0xFF, PRDATA=0x0000005A with PREADY in first ACCESS cycle, PSLVERR=0.
REQ-038 WAIT_STATES=3, read 0x04 -> PREADY low for 3 ACCESS cycles, high on 4th, PRDATA valid only then.
REQ-039 RISE_EN=0x01, drive gpio_in[0] 0->1 -> STATUS=0x01 and irq=1 on 3rd edge; write 0x01 to 0x14 -> STATUS=0, irq=0; falling edge with FALL_EN=0 -> no set.
REQ-040 Rising edge on pin 0 coincident with W1C of bit 0 -> STATUS[0] remains 1.
REQ-041 Write to 0x18, to 0x08, to 0x02, and write with PPROT=3'b000 -> each PSLVERR=1 with PREADY, no register changes; read 0x18 -> PRDATA=0.
REQ-042 Assert PRESET mid-ACCESS of a write 0xAA to 0x00 with WAIT_STATES=2 -> DOUT stays 0, PREADY=0, FSM in IDLE next cycle.
